// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 codes, FSM state encoding and request-decode helpers
//            for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    // Stores only accept the signed widths; loads also accept the unsigned ones.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic addr_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        case (funct3)
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational lane logic: load byte/half extract with sign or zero
//            extension, and sub-word store merge into an existing word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_byte_mask;
    logic [31:0] w_byte_rep;

    // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
    assign w_shamt     = {i_addr_lo, 3'b000};
    assign w_shifted   = i_word >> w_shamt;
    assign w_byte      = w_shifted[7:0];
    assign w_half      = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    assign w_byte_mask = 32'h0000_00FF << w_shamt;
    assign w_byte_rep  = {4{i_wdata[7:0]}};

    always_comb begin
        o_rdata = i_word;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'h000000, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'h0000, w_half};
            default: o_rdata = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_wdata;
        case (i_funct3)
            F3_B:    o_merged = (i_word & ~w_byte_mask) | (w_byte_rep & w_byte_mask);
            F3_H:    o_merged = i_addr_lo[1] ? {i_wdata[15:0], i_word[15:0]}
                                             : {i_word[31:16], i_wdata[15:0]};
            default: o_merged = i_wdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : Byte-addressed RISC-V load/store front end for a word-addressed
//            data memory; sub-word stores use read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

    lsu_state_t  r_state;
    lsu_state_t  w_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;

    logic        w_req_err;
    logic        w_req_rmw;
    logic [31:0] w_align_word;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_req_err = ~f3_legal(req_we, req_funct3)
                     | ~addr_aligned(req_funct3, req_addr[1:0])
                     | ((req_addr >> 2) >= c_mem_words);
    assign w_req_rmw = req_we & (req_funct3 != F3_W);

    // Loads extract straight from the memory word during READ; the store merge
    // works on the word captured at the end of READ.
    assign w_align_word = (r_state == READ) ? dm_rdata : r_word;

    lsu_align u_align (
        .i_word    (w_align_word),
        .i_wdata   (r_wdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_rdata   (w_load_data),
        .o_merged  (w_merged)
    );

    assign dm_addr  = {2'b00, r_addr[31:2]};
    assign dm_wdata = w_merged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        dm_read    = 1'b0;
        dm_write   = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next = DONE;
                    end else if (!req_we || w_req_rmw) begin
                        w_next = READ;
                    end else begin
                        w_next = WRITE;
                    end
                end
            end
            READ: begin
                dm_read = 1'b1;
                w_next  = r_we ? WRITE : DONE;
            end
            WRITE: begin
                dm_write = 1'b1;
                w_next   = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_word     <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_req_err) begin
                            resp_rdata <= 32'h0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_word <= dm_rdata;
                    if (!r_we) begin
                        resp_rdata <= w_load_data;
                        resp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit with a simple
//            word memory preloaded with word i = i*10.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:1023];
    logic        mem_load;
    logic        both_seen;
    int          n_total;
    int          n_bad;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_read    (dm_read),
        .dm_write   (dm_write),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata = (dm_addr < 32'd1024) ? mem[dm_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i * 10);
        end else if (dm_write && dm_addr < 32'd1024) begin
            mem[dm_addr[9:0]] <= dm_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_rd, input int exp_wr,
                          output logic [31:0] seen_addr, output logic [31:0] seen_wdata);
        int lat, rd, wr;
        seen_addr  = 32'h0;
        seen_wdata = 32'h0;
        wait_ready(tag);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5555_5555;
        lat = 1;
        rd  = 0;
        wr  = 0;
        while (!resp_valid && lat < 10) begin
            if (dm_read && dm_write) both_seen = 1'b1;
            if (dm_read) begin
                rd++;
                seen_addr = dm_addr;
            end
            if (dm_write) begin
                wr++;
                seen_addr  = dm_addr;
                seen_wdata = dm_wdata;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":rdata"}, resp_rdata, exp_rdata);
        check({tag, ":err"}, {31'b0, resp_err}, {31'b0, exp_err});
        check({tag, ":reads"}, 32'(rd), 32'(exp_rd));
        check({tag, ":writes"}, 32'(wr), 32'(exp_wr));
    endtask

    initial begin
        logic [31:0] sa, sw;
        int          resp_cnt;
        n_total    = 0;
        n_bad      = 0;
        both_seen  = 1'b0;
        mem_load   = 1'b1;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst:req_ready", {31'b0, req_ready}, 32'd1);
        check("rst:resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst:resp_rdata", resp_rdata, 32'h0);
        check("rst:resp_err", {31'b0, resp_err}, 32'd0);
        check("rst:strobes", {30'b0, dm_read, dm_write}, 32'd0);
        check("rst:dm_addr", dm_addr, 32'h0);
        check("rst:dm_wdata", dm_wdata, 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        mem_load = 1'b0;

        do_req("lw14", 1'b0, 3'b010, 32'h14, 32'h0, 32'h0000_0032, 1'b0, 2, 1, 0, sa, sw);
        check("lw14:dm_addr", sa, 32'd5);
        do_req("sw20", 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1, sa, sw);
        check("sw20:dm_addr", sa, 32'd8);
        check("sw20:dm_wdata", sw, 32'hDEAD_BEEF);
        do_req("lb23", 1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 1, 0, sa, sw);
        do_req("lbu23", 1'b0, 3'b100, 32'h23, 32'h0, 32'h0000_00DE, 1'b0, 2, 1, 0, sa, sw);
        do_req("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, 1, 0, sa, sw);
        do_req("lhu20", 1'b0, 3'b101, 32'h20, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1, 0, sa, sw);
        do_req("sb21", 1'b1, 3'b000, 32'h21, 32'h1234_5677, 32'h0, 1'b0, 3, 1, 1, sa, sw);
        check("sb21:dm_wdata", sw, 32'hDEAD_77EF);
        do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_77EF, 1'b0, 2, 1, 0, sa, sw);

        do_req("err_sh15", 1'b1, 3'b001, 32'h15, 32'hAAAA_AAAA, 32'h0, 1'b1, 1, 0, 0, sa, sw);
        do_req("lw20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_77EF, 1'b0, 2, 1, 0, sa, sw);
        do_req("err_lw22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0, 0, sa, sw);
        do_req("err_lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0, sa, sw);
        do_req("err_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0, sa, sw);
        check("mem:word5", mem[5], 32'd50);

        // Back-to-back loads with req_valid held high throughout.
        wait_ready("b2b");
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        @(posedge clk); #1;
        check("b2b:ready_read1", {31'b0, req_ready}, 32'd0);
        req_addr = 32'h18;
        @(posedge clk); #1;
        check("b2b:ready_done1", {31'b0, req_ready}, 32'd0);
        check("b2b:resp1_valid", {31'b0, resp_valid}, 32'd1);
        check("b2b:resp1_rdata", resp_rdata, 32'h0000_0032);
        @(posedge clk); #1;
        check("b2b:ready_idle", {31'b0, req_ready}, 32'd1);
        check("b2b:no_resp_idle", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("b2b:accept2", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b:resp2_valid", {31'b0, resp_valid}, 32'd1);
        check("b2b:resp2_rdata", resp_rdata, 32'h0000_003C);

        // Reset during the READ phase of SB 0x08.
        wait_ready("rstmid");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h08;
        req_wdata  = 32'h0000_00AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid:dm_read_before", {31'b0, dm_read}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid:dm_read_async", {31'b0, dm_read}, 32'd0);
        check("rstmid:dm_write_async", {31'b0, dm_write}, 32'd0);
        resp_cnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) resp_cnt++;
            if (dm_write) both_seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid:ready_after", {31'b0, req_ready}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) resp_cnt++;
        end
        check("rstmid:no_resp", 32'(resp_cnt), 32'd0);
        check("rstmid:word2", mem[2], 32'd20);
        do_req("lw08", 1'b0, 3'b010, 32'h08, 32'h0, 32'h0000_0014, 1'b0, 2, 1, 0, sa, sw);

        check("strobe_exclusive", {31'b0, both_seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute stage and the word-addressed data_memory. It converts byte-addressed RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Loads: selects and sign/zero-extends the addressed byte or half.
- Sub-word stores: performs a read-modify-write sequence.
- Misaligned, out-of-range and illegal requests: flagged as errors without touching memory.
- Protocol: valid/ready request, one-cycle response pulse.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in data memory; valid word index is 0..MEM_WORDS-1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data
resp_err  output  1  request rejected, valid with resp_valid
dm_read  output  1  memory read strobe
dm_write  output  1  memory write strobe
dm_addr  output  32  word index = captured addr >> 2
dm_wdata  output  32  merged write word
dm_rdata  input  32  memory read data, combinational while dm_read=1

Behaviour:
- Reset (async, immediate): state=IDLE. All of the following are 0: resp_valid, resp_rdata, resp_err, dm_read, dm_write, dm_addr, dm_wdata, and the captured request registers. Since state=IDLE, req_ready=1; no acceptance occurs while reset is high.
- Acceptance: req_valid & req_ready at a rising edge. req_we, funct3, addr and wdata are registered; later input changes are ignored.
- States: IDLE, READ, WRITE, DONE.
- Decode at acceptance; err if any of:
  - load funct3 is 011, 110 or 111;
  - store funct3 is not 000, 001 or 010;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - (addr>>2) ≥ MEM_WORDS.
- Transitions from IDLE on accept:
  - err → DONE;
  - load → READ;
  - SB/SH → READ;
  - SW → WRITE.
- READ:
  - dm_read=1 for exactly one cycle.
  - Edge capture of dm_rdata into an internal word register.
  - Next state: load → DONE; SB/SH → WRITE.
- WRITE:
  - dm_write=1 for exactly one cycle.
  - dm_wdata: for SW, equals wdata; for SB/SH, the captured word with the target byte/half replaced, lane = addr[1:0] (byte) or addr[1] (half), little-endian.
  - Next state → DONE.
- dm_read and dm_write are never high together. Both are 0 in IDLE and DONE. dm_addr and dm_wdata are stable while a strobe is high.
- DONE: resp_valid=1 for one cycle, req_ready=0. Next state → IDLE.
- resp_rdata:
  - loaded on entry to DONE;
  - loads: LB/LH sign-extend, LBU/LHU zero-extend, LW full word;
  - stores and errors: 0;
  - holds its value until the next DONE.
- resp_err: loaded on entry to DONE, held until the next DONE.
- Latency from acceptance edge to resp_valid:
  - error: 1 cycle;
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles.
- Throughput: the next acceptance is no earlier than the cycle after DONE.
- Reset mid-operation: strobes drop asynchronously and the request is abandoned with no response. A reset during READ of an SB/SH leaves memory unmodified.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding (2-bit) IDLE/READ/WRITE/DONE.
- Sub-module lsu_align (combinational), shared by both paths:
  - load extract/extend (word, addr[1:0], funct3 → rdata);
  - store merge (old word, wdata, addr[1:0], funct3 → new word).
- Top-level load_store_unit holds the FSM, capture registers and response registers.

Test Plan:
The bench memory model is preloaded with word i = i*10.
- LW 0x14 → dm_read one cycle, dm_addr=5; resp_valid 2 cycles after accept, resp_rdata=0x00000032, resp_err=0.
- SW 0x20 data 0xDEADBEEF, then:
  - LB 0x23 → 0xFFFFFFDE;
  - LBU 0x23 → 0x000000DE;
  - LH 0x22 → 0xFFFFDEAD;
  - LHU 0x20 → 0x0000BEEF.
- After that SW, SB 0x21 data 0x12345677 → dm_read then dm_write, one cycle each, dm_wdata=0xDEAD77EF; resp_valid 3 cycles after accept; LW 0x20 → 0xDEAD77EF.
- Error rejections, each with resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, and dm_read/dm_write never asserted:
  - SH 0x15;
  - LW 0x22;
  - LW 0x1000 (word 1024);
  - load funct3=011.
- Back-to-back: req_valid held high for two loads → req_ready low during READ/DONE, second accepted the cycle after DONE, both responses correct and in order.
- Reset asserted during the READ cycle of SB 0x08 → dm_read drops immediately, no resp_valid, word 2 still 20; after release req_ready=1 and a new LW 0x08 returns 0x00000014.
